// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank controllers: FSM states, bank widths
// and default timing parameters.
package gpio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIZ   = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam int BANK_A_WIDTH    = 32;
  localparam int BANK_B_WIDTH    = 32;
  localparam int BANK_C_WIDTH    = 8;
  localparam int TURN_CYCLES_DEF = 2;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser that brings asynchronous pad levels into the clk domain.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bank_ctrl.sv
// Direction/output update sequencer for one tristate GPIO bank. Pins whose
// direction changes are parked Hi-Z for TURN_CYCLES before being re-driven.
module gpio_bank_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = BANK_A_WIDTH,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dir,
  input  logic [WIDTH-1:0] req_out,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_oe,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output logic             busy
);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 15) begin : g_bad_turn
    $error("gpio_bank_ctrl: TURN_CYCLES must be within 1..15");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("gpio_bank_ctrl: SYNC_STAGES must be within 2..4");
  end

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] cur_dir;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] turn_mask;

  // Pins in turn_mask are held Hi-Z during HIZ; all others keep driving and
  // pick up their new level early, so output-only changes never drop pin_oe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_dir   <= '0;
      dir_q     <= '0;
      out_q     <= '0;
      turn_mask <= '0;
      pin_oe    <= '0;
      pin_out   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            dir_q     <= req_dir;
            out_q     <= req_out;
            turn_mask <= cur_dir ^ req_dir;
            if ((cur_dir ^ req_dir) == '0) begin
              state <= APPLY;
            end else begin
              state <= HIZ;
              cnt   <= 4'(TURN_CYCLES - 1);
            end
          end
        end
        HIZ: begin
          pin_oe  <= pin_oe & ~turn_mask;
          pin_out <= (pin_out & turn_mask) | (out_q & ~turn_mask);
          if (cnt == 4'd0) state <= APPLY;
          else             cnt   <= cnt - 4'd1;
        end
        APPLY: begin
          pin_oe  <= dir_q;
          cur_dir <= dir_q;
          pin_out <= out_q;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (pin_in),
    .q      (rd_data)
  );

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed, table-driven bench for gpio_bank_ctrl (32-pin bank, 2-cycle turnaround).
module tb_gpio_bank_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_dir;
  logic [31:0] req_out;
  logic [31:0] pin_in;
  logic [31:0] pin_oe;
  logic [31:0] pin_out;
  logic [31:0] rd_data;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  gpio_bank_ctrl #(.WIDTH(32), .TURN_CYCLES(2), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_dir  (req_dir),
    .req_out  (req_out),
    .pin_in   (pin_in),
    .pin_oe   (pin_oe),
    .pin_out  (pin_out),
    .rd_data  (rd_data),
    .done     (done),
    .busy     (busy)
  );

  typedef struct {
    logic [31:0] dir;
    logic [31:0] out;
    bit          turn;
    logic [31:0] hiz_oe;
    logic [31:0] hiz_out;
    logic [31:0] exp_oe;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [7];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) check_output("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [31:0] prev_oe;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b1;
    req_dir   = v.dir;
    req_out   = v.out;
    prev_oe   = pin_oe;
    check_output("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_output("oe_hold_at_transfer", pin_oe, prev_oe);
    if (v.turn) begin
      for (int c = 0; c < 2; c++) begin
        @(posedge clk); #1;
        check_output("hiz_oe", pin_oe, v.hiz_oe);
        check_output("hiz_out", pin_out, v.hiz_out);
        check_output("hiz_done", 32'(done), 32'd0);
        check_output("hiz_busy", 32'(busy), 32'd1);
      end
    end
    @(posedge clk); #1;
    check_output("apply_oe", pin_oe, v.exp_oe);
    check_output("apply_out", pin_out, v.exp_out);
    check_output("apply_done", 32'(done), 32'd1);
    check_output("apply_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check_output("done_pulse_end", 32'(done), 32'd0);
  endtask

  // An output-enable bit may only rise on the cycle the new configuration is applied.
  always begin
    logic [31:0] last_oe;
    @(posedge clk); #1;
    last_oe = pin_oe;
    forever begin
      @(posedge clk); #1;
      if (mon_en && reset_n && ((pin_oe & ~last_oe) != '0))
        check_output("oe_rise_only_on_apply", 32'(done), 32'd1);
      last_oe = pin_oe;
    end
  end

  initial begin
    logic [31:0] model_dir;
    logic [31:0] rdir, rout;
    int          lat;

    vecs[0] = '{32'hFFFFFFFF, 32'h12345678, 1'b1, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
    vecs[1] = '{32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hA5A5A5A5};
    vecs[2] = '{32'h0000FFFF, 32'h0F0F0F0F, 1'b1, 32'h0000FFFF, 32'hA5A50F0F, 32'h0000FFFF, 32'h0F0F0F0F};
    vecs[3] = '{32'hFFFF0000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h0F0F0F0F, 32'hFFFF0000, 32'hFFFFFFFF};
    vecs[4] = '{32'hFFFF0000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        32'hFFFF0000, 32'hFFFFFFFF};
    vecs[5] = '{32'hFFFF00FF, 32'h00000000, 1'b1, 32'hFFFF0000, 32'h000000FF, 32'hFFFF00FF, 32'h00000000};
    vecs[6] = '{32'h00000000, 32'hDEADBEEF, 1'b1, 32'h00000000, 32'h0000BE00, 32'h00000000, 32'hDEADBEEF};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_dir   = '0;
    req_out   = '0;
    pin_in    = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_oe", pin_oe, 32'h0);
    check_output("rst_out", pin_out, 32'h0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_rd_data", rd_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    #1;
    check_output("rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check_output("sync_one_stage", rd_data, 32'h0);
    @(posedge clk); #1;
    check_output("sync_two_stages", rd_data, 32'hFFFFFFFF);

    @(negedge clk);
    pin_in = 32'h3C3C3C3C;
    @(posedge clk); #1;
    check_output("sync_old_value", rd_data, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check_output("sync_new_value", rd_data, 32'h3C3C3C3C);

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

    // Backpressure: data changes while busy are ignored; the held request
    // is only taken again once the controller is back in IDLE.
    @(negedge clk);
    req_valid = 1'b1;
    req_dir   = 32'hFFFFFFFF;
    req_out   = 32'h11111111;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      req_dir = 32'h00000000;
      req_out = 32'h22222222 + 32'(c);
      @(posedge clk); #1;
      check_output("bp_ready_low", 32'(req_ready), 32'd0);
      check_output("bp_hiz_oe", pin_oe, 32'h0);
    end
    req_dir = 32'hFFFFFFFF;
    req_out = 32'h33333333;
    @(posedge clk); #1;
    check_output("bp_first_oe", pin_oe, 32'hFFFFFFFF);
    check_output("bp_first_out", pin_out, 32'h11111111);
    check_output("bp_first_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_output("bp_second_pending", 32'(done), 32'd0);
    check_output("bp_second_out_old", pin_out, 32'h11111111);
    @(posedge clk); #1;
    check_output("bp_second_out", pin_out, 32'h33333333);
    check_output("bp_second_done", 32'(done), 32'd1);

    // Asynchronous reset during HIZ.
    wait_ready();
    @(negedge clk);
    req_valid = 1'b1;
    req_dir   = 32'hFFFF0000;
    req_out   = 32'h00000000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_output("midhiz_oe", pin_oe, 32'hFFFF0000);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_oe", pin_oe, 32'h0);
    check_output("async_rst_out", pin_out, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_output("dropped_req_oe", pin_oe, 32'h0);
      check_output("dropped_req_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_dir   = 32'h0;
    req_out   = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_output("post_rst_dir_zero_done", 32'(done), 32'd1);
    check_output("post_rst_out", pin_out, 32'h55AA55AA);

    // Random requests: latency depends on whether any direction bit changes.
    model_dir = 32'h0;
    for (int r = 0; r < 1000; r++) begin
      rdir = ($urandom_range(0, 2) == 0) ? model_dir : $urandom;
      rout = $urandom;
      wait_ready();
      @(negedge clk);
      req_valid = 1'b1;
      req_dir   = rdir;
      req_out   = rout;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      for (int t = 1; t <= 10; t++) begin
        @(posedge clk); #1;
        if (done) begin
          lat = t;
          break;
        end
      end
      check_output("rand_latency", 32'(lat), (rdir != model_dir) ? 32'd3 : 32'd1);
      check_output("rand_oe", pin_oe, rdir);
      check_output("rand_out", pin_out, rout);
      model_dir = rdir;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
